parking_occupancy: RTL and testbench

Occupancy tracker that sits directly downstream of the parking-lot sensor FSM and consumes its one-cycle `enter` (car fully in) and `exit` (car fully out) pulses. It keeps a saturating car count against a fixed capacity, tracks the count in BCD for the two-digit lot display, and drives the full/empty status and the entry-permitted signal. It also holds sticky overflow/underflow error flags for the supervisor.

---
 rtl/parking_occupancy.sv | 111 +++++++++++
 tb/tb_parking_occupancy.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy.sv
// parking_occupancy: saturating car counter downstream of the lot sensor FSM.
// Counts enter/exit pulses against CAPACITY, keeps BCD display digits in step
// with the binary count, and raises sticky overflow/underflow flags.
//
// Handshake: enter and exit are single-cycle event pulses with no ready/back-
// pressure; every sampled high cycle is one event, one event per cycle max.
// enter and exit together in one cycle cancel out and change nothing.
module parking_occupancy #(
  parameter int CAPACITY = 20,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             exit,
  input  logic             clear_err,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             full,
  output logic             empty,
  output logic             lot_open,
  output logic             ovf_err,
  output logic             unf_err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] count_n;
  logic [3:0]       tens_n, ones_n;
  logic             ovf_n, unf_n;
  logic             inc, dec;

  // State, count, BCD digits and error flags all update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      count   <= '0;
      tens    <= 4'd0;
      ones    <= 4'd0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      tens    <= tens_n;
      ones    <= ones_n;
      ovf_err <= ovf_n;
      unf_err <= unf_n;
    end
  end

  // Event decode: saturating step of count/BCD/state plus error flag update.
  always_comb begin
    state_n = state;
    count_n = count;
    tens_n  = tens;
    ones_n  = ones;
    inc     = enter & ~exit;
    dec     = exit & ~enter;
    // Clearing only drops a flag that is not being set this same cycle.
    ovf_n   = ovf_err & ~clear_err;
    unf_n   = unf_err & ~clear_err;

    if (inc) begin
      if (state == ST_FULL) begin
        ovf_n = 1'b1;
      end else begin
        count_n = count + ONE;
        if (ones == 4'd9) begin
          ones_n = 4'd0;
          tens_n = tens + 4'd1;
        end else begin
          ones_n = ones + 4'd1;
        end
        state_n = (count_n == CAP) ? ST_FULL : ST_PARTIAL;
      end
    end else if (dec) begin
      if (state == ST_EMPTY) begin
        unf_n = 1'b1;
      end else begin
        count_n = count - ONE;
        if (ones == 4'd0) begin
          ones_n = 4'd9;
          tens_n = tens - 4'd1;
        end else begin
          ones_n = ones - 4'd1;
        end
        state_n = (count == ONE) ? ST_EMPTY : ST_PARTIAL;
      end
    end
  end

  // Status is a pure decode of the state register, so it tracks count exactly.
  always_comb begin
    full      = (state == ST_FULL);
    empty     = (state == ST_EMPTY);
    lot_open  = ~full;
    state_dbg = state;
  end

endmodule

// File: tb/tb_parking_occupancy.sv
// Directed bench for parking_occupancy with CAPACITY=20.
module tb_parking_occupancy;

  localparam int CAPACITY = 20;
  localparam int CNT_W    = 7;

  logic             clk = 1'b0;
  logic             reset, enter, exit, clear_err;
  logic [CNT_W-1:0] count;
  logic [3:0]       tens, ones;
  logic             full, empty, lot_open, ovf_err, unf_err;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  parking_occupancy #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enter(enter), .exit(exit),
    .clear_err(clear_err), .count(count), .tens(tens), .ones(ones),
    .full(full), .empty(empty), .lot_open(lot_open),
    .ovf_err(ovf_err), .unf_err(unf_err), .state_dbg(state_dbg)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Observed outputs packed: count, tens, ones, full, empty, lot_open, ovf, unf, state.
  logic [21:0] obs;
  assign obs = {count, tens, ones, full, empty, lot_open, ovf_err, unf_err, state_dbg};

  // Reference model: expected output vector for a given occupancy and flags.
  function automatic logic [21:0] exp_vec(input int c, input bit ov, input bit un);
    logic [CNT_W-1:0] ec;
    logic [3:0]       et, eo;
    logic             ef, ee;
    logic [1:0]       es;
    ec = CNT_W'(c);
    et = 4'(c / 10);
    eo = 4'(c % 10);
    ef = (c == CAPACITY);
    ee = (c == 0);
    es = ee ? 2'd0 : (ef ? 2'd2 : 2'd1);
    return {ec, et, eo, ef, ee, ~ef, ov, un, es};
  endfunction

  // Driver: apply inputs for exactly one rising edge, then return to idle.
  task automatic step(input bit e, input bit x, input bit c, input bit r);
    @(negedge clk);
    enter = e; exit = x; clear_err = c; reset = r;
    @(posedge clk);
    #1;
    enter = 1'b0; exit = 1'b0; clear_err = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    logic [21:0] e;
    do_reset();
    e = exp_vec(0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_values: got %h expected %h", obs, e); end
  endtask

  task automatic test_three_enters();
    logic [21:0] e;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0);
      e = exp_vec(i, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL enter_%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_fill_overflow();
    logic [21:0] e;
    do_reset();
    for (int i = 1; i <= CAPACITY; i++) begin
      step(1, 0, 0, 0);
      e = exp_vec(i, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL fill_%0d: got %h expected %h", i, obs, e); end
    end
    step(1, 0, 0, 0);
    e = exp_vec(CAPACITY, 1, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL overflow: got %h expected %h", obs, e); end
    step(0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ovf_sticky: got %h expected %h", obs, e); end
    step(1, 0, 1, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ovf_set_wins: got %h expected %h", obs, e); end
    step(0, 0, 1, 0);
    e = exp_vec(CAPACITY, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ovf_clear: got %h expected %h", obs, e); end
  endtask

  task automatic test_bcd_borrow_carry();
    logic [21:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    e = exp_vec(10, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL at_ten: got %h expected %h", obs, e); end
    step(0, 1, 0, 0);
    e = exp_vec(9, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL borrow_to_9: got %h expected %h", obs, e); end
    step(1, 0, 0, 0);
    e = exp_vec(10, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL carry_to_10: got %h expected %h", obs, e); end
  endtask

  task automatic test_underflow();
    logic [21:0] e;
    do_reset();
    step(0, 1, 0, 0);
    e = exp_vec(0, 0, 1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL underflow: got %h expected %h", obs, e); end
    step(0, 1, 1, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL unf_set_wins: got %h expected %h", obs, e); end
    step(0, 0, 1, 0);
    e = exp_vec(0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL unf_clear: got %h expected %h", obs, e); end
  endtask

  task automatic test_simultaneous();
    logic [21:0] e;
    do_reset();
    step(1, 1, 0, 0);
    e = exp_vec(0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL both_at_0: got %h expected %h", obs, e); end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    e = exp_vec(5, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL both_at_5: got %h expected %h", obs, e); end
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    e = exp_vec(20, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL both_at_20: got %h expected %h", obs, e); end
  endtask

  task automatic test_reset_mid_burst();
    logic [21:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    e = exp_vec(7, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL at_seven: got %h expected %h", obs, e); end
    step(1, 0, 0, 1);
    e = exp_vec(0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_with_enter: got %h expected %h", obs, e); end
    step(1, 0, 0, 0);
    e = exp_vec(1, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL enter_after_reset: got %h expected %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    int c;
    do_reset();
    c = 0;
    // Rise through 18, drain to 0, then alternate: every cycle an event.
    for (int i = 0; i < 18; i++) begin
      step(1, 0, 0, 0);
      c++;
    end
    for (int i = 0; i < 18; i++) begin
      step(0, 1, 0, 0);
      c--;
      e = exp_vec(c, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL drain_%0d: got %h expected %h", c, obs, e); end
    end
    for (int i = 0; i < 6; i++) begin
      step((i % 2) == 0, (i % 2) == 1, 0, 0);
      c = c + (((i % 2) == 0) ? 1 : -1);
      e = exp_vec(c, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL alternate_%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; exit = 1'b0; clear_err = 1'b0;
    test_reset();
    test_three_enters();
    test_fill_overflow();
    test_bcd_borrow_carry();
    test_underflow();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
